// File: rtl/fmv_ddr_pkg.sv
`default_nettype none
// ============================================================================
// fmv_ddr_pkg : shared constants, FSM state type and index helper for the
//               FMV DDR burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fmv_ddr_pkg;

    localparam int         c_num_req       = 3;
    localparam logic [3:0] c_ddr_core_base = 4'b0011;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_CMD   = 2'd1,
        READ_DATA  = 2'd2,
        WRITE_DATA = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_if.sv
`default_nettype none
// ============================================================================
// ddr_if   : shared burst port between the arbiter (host) and the DDR core.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_if;

    logic [28:0] addr;
    logic        read;
    logic        write;
    logic [7:0]  burstcnt;
    logic [63:0] wdata;
    logic [7:0]  byteenable;
    logic        acquire;
    logic        busy;
    logic [63:0] rdata;
    logic        rdata_ready;

    modport to_host (
        output addr, read, write, burstcnt, wdata, byteenable, acquire,
        input  busy, rdata, rdata_ready
    );

    modport to_ddr (
        input  addr, read, write, burstcnt, wdata, byteenable, acquire,
        output busy, rdata, rdata_ready
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick; requester 0 always wins when
//              pending, otherwise search starts after the last grant.
// Revision   : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import fmv_ddr_pkg::*;
#(
    parameter int NUM_REQ = c_num_req,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_found;

    always_comb begin
        gnt        = '0;
        gnt_idx    = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        if (req[0]) begin
            gnt[0]  = 1'b1;
            w_found = 1'b1;
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand     = (int'(last_idx) + k) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                gnt[w_cand_idx] = 1'b1;
                gnt_idx         = w_cand_idx;
                w_found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmv_ddr_arbiter.sv
`default_nettype none
// ============================================================================
// fmv_ddr_arbiter : grants the shared DDR burst port to one of NUM_REQ
//                   requesters and sequences the read or write burst.
// Revision        : 1.0 - initial release
// ============================================================================
module fmv_ddr_arbiter
    import fmv_ddr_pkg::*;
#(
    parameter int         NUM_REQ       = c_num_req,
    parameter logic [3:0] DDR_CORE_BASE = c_ddr_core_base
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][28:0] req_addr,
    input  logic [NUM_REQ-1:0][7:0]  req_burstcnt,
    input  logic [NUM_REQ-1:0][63:0] req_wdata,
    input  logic [NUM_REQ-1:0][7:0]  req_byteenable,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       wdata_ack,
    output logic [NUM_REQ-1:0]       rdata_ready,
    output logic [63:0]              rdata,
    output logic [NUM_REQ-1:0]       done,
    ddr_if.to_host                   ddrif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [28:0]        r_addr;
    logic [7:0]         r_burstcnt;
    logic [7:0]         r_cnt;
    logic [NUM_REQ-1:0] r_done;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_win;
    logic               w_start;
    logic               w_finish;
    logic               w_beat;
    logic               w_unused;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .last_idx (r_ptr),
        .gnt      (w_arb_gnt),
        .gnt_idx  (w_arb_idx)
    );

    // The finishing owner still holds req_valid during its done cycle, so
    // arbitration waits one more IDLE cycle to avoid re-granting a stale request.
    assign w_win      = (|w_arb_gnt) && (r_done == '0);
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_start    = (r_state == IDLE) && (w_next_state != IDLE);
    assign w_finish   = (r_state != IDLE) && (w_next_state == IDLE);
    assign w_beat     = ((r_state == READ_DATA) && ddrif.rdata_ready) ||
                        ((r_state == WRITE_DATA) && !ddrif.busy);
    assign w_unused   = ^req_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_addr     <= '0;
            r_burstcnt <= '0;
            r_cnt      <= '0;
            r_done     <= '0;
        end else begin
            r_done <= w_finish ? w_owner_oh : '0;
            if (w_start) begin
                r_owner    <= w_arb_idx;
                r_ptr      <= w_arb_idx;
                r_addr     <= {DDR_CORE_BASE, req_addr[w_arb_idx][27:3]};
                r_burstcnt <= req_burstcnt[w_arb_idx];
                r_cnt      <= req_burstcnt[w_arb_idx];
            end else if (w_beat && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Zero-length bursts of either direction park in WRITE_DATA for one
    // cycle with write held low, which gives the grant-then-done behaviour.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_win) begin
                    if (req_write[w_arb_idx] || (req_burstcnt[w_arb_idx] == 8'd0)) begin
                        w_next_state = WRITE_DATA;
                    end else begin
                        w_next_state = READ_CMD;
                    end
                end
            end
            READ_CMD: begin
                if (!ddrif.busy) begin
                    w_next_state = READ_DATA;
                end
            end
            READ_DATA: begin
                if ((r_cnt == 8'd0) || (ddrif.rdata_ready && (r_cnt == 8'd1))) begin
                    w_next_state = IDLE;
                end
            end
            WRITE_DATA: begin
                if ((r_cnt == 8'd0) || (!ddrif.busy && (r_cnt == 8'd1))) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        grant       = '0;
        wdata_ack   = '0;
        rdata_ready = '0;
        done        = r_done;
        if (r_state != IDLE) begin
            grant = w_owner_oh;
        end
        if ((r_state == WRITE_DATA) && (r_cnt != 8'd0) && !ddrif.busy) begin
            wdata_ack = w_owner_oh;
        end
        if ((r_state == READ_DATA) && (r_cnt != 8'd0) && ddrif.rdata_ready) begin
            rdata_ready = w_owner_oh;
        end
    end

    assign rdata            = ddrif.rdata;
    assign ddrif.addr       = r_addr;
    assign ddrif.burstcnt   = r_burstcnt;
    assign ddrif.acquire    = (r_state != IDLE);
    assign ddrif.read       = (r_state == READ_CMD);
    assign ddrif.write      = (r_state == WRITE_DATA) && (r_cnt != 8'd0);
    assign ddrif.wdata      = req_wdata[r_owner];
    assign ddrif.byteenable = (r_state == WRITE_DATA) ? req_byteenable[r_owner] : 8'hff;

endmodule
`default_nettype wire
